shift_req_buffer: RTL and testbench
===================================

SHIFT_REQ_BUFFER -- requirements
Module: shift_req_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of request entries; SHALL be a power of two and at least 2.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  producer presents a rotate request.
REQ-005 in_ready  output  1  buffer can accept a request this cycle.
REQ-006 in_data  input  32  operand to be right-rotated.
REQ-007 in_shift  input  5  right-rotate amount, 0..31.
REQ-008 out_valid  output  1  head request is available to the downstream 32-bit right barrel rotator.
REQ-009 out_ready  input  1  downstream consumes the head request this cycle.
REQ-010 out_data  output  32  head operand, driven to the rotator's A input.
REQ-011 out_shift  output  5  head rotate amount, driven to the rotator's shift input.
REQ-012 count  output  $clog2(DEPTH)+1  number of occupied entries.
REQ-013 ovf  output  1  sticky overflow flag; exists only when SHIFT_REQ_OVF_EN is defined.

Function
REQ-014 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-015 Ordering SHALL be strict FIFO; each entry stores {in_data, in_shift} unmodified, with no rotation inside this block.
REQ-016 in_ready SHALL be (count != DEPTH); out_valid SHALL be (count != 0); both are derived from registered state only, with no combinational path from in_valid or out_ready.
REQ-017 Latency: a request pushed at edge N SHALL appear on out_* with out_valid=1 in the cycle after edge N; there is no same-cycle bypass.
REQ-018 When out_valid=1 and out_ready=0, out_data and out_shift SHALL remain stable.
REQ-019 When count=0, out_data and out_shift SHALL be driven to 0.
REQ-020 Push without pop: count+1. Pop without push: count-1. Push and pop together: count unchanged, head advances, new entry is written at the tail.
REQ-021 Full (count=DEPTH): in_ready=0, so push is impossible even when out_ready=1 in the same cycle; the freed slot becomes available in the next cycle.
REQ-022 Empty (count=0): out_valid=0, so out_ready is ignored.
REQ-023 Read and write pointers SHALL be log2(DEPTH) bits wide and wrap from DEPTH-1 to 0 modulo DEPTH.
REQ-024 in_data and in_shift SHALL be ignored when no push occurs.

Reset
REQ-025 While rst=1 at a rising edge: pointers=0, count=0, out_valid=0, in_ready=1, out_data=0, out_shift=0, and ovf=0 if present.
REQ-026 Reset asserted mid-operation SHALL discard all stored requests; storage array contents need not be cleared.
REQ-027 Reset SHALL take priority over simultaneous push and pop.

Configuration
REQ-028 Macro SHIFT_REQ_OVF_EN:
- Defined: port ovf exists. It SHALL set at the first edge where in_valid=1 && in_ready=0, hold at 1 until rst, and the offered request SHALL be dropped.
- Undefined: port ovf and its logic are absent. Requests offered while full are simply not accepted, and the producer must hold them.

Verification
REQ-029 Reset, then push in_data=0x80000001, in_shift=1 -> next cycle out_valid=1, out_data=0x80000001, out_shift=1, count=1; downstream rotator output is 0xC0000000.
REQ-030 DEPTH=4: push 0x11111111, 0x22222222, 0x33333333, 0x44444444 with out_ready=0 -> count=4, in_ready=0; then pop 4 times -> outputs appear in the same order, and count=0, out_data=0 at the end.
REQ-031 count=2 with simultaneous push and pop for 10 cycles -> count remains 2, pointers wrap, FIFO order is preserved.
REQ-032 Full, with in_valid=1 and out_ready=1 -> no push that cycle, one pop, count=3, in_ready=1 in the next cycle; with SHIFT_REQ_OVF_EN defined, ovf=1 and stays 1.
REQ-033 count=3, assert rst for one cycle with in_valid=1 and out_ready=1 -> count=0, out_valid=0, out_data=0, in_ready=1, ovf=0.
REQ-034 in_shift=31, in_data=0x00000001 through the buffer and rotator -> rotator output 0x00000002; in_shift=0 -> output equals in_data.

Source files
------------

// File: rtl/shift_req_buffer.sv
// -----------------------------------------------------------------------------
// shift_req_buffer
//
// Purpose:
//   Small FIFO that queues rotate requests {operand, amount} in front of a
//   32-bit right barrel rotator. The buffer only stores and orders requests.
//   It performs no rotation. The head request is presented on out_data and
//   out_shift.
//
//   All outputs are registered. The head payload, out_valid and in_ready are
//   computed for the next cycle and loaded at the same edge that updates the
//   pointers. As a result, no combinational path runs from in_valid or
//   out_ready to any output.
//
// Parameters:
//   DEPTH      number of entries; must be a power of two and >= 2
//
// Optional feature:
//   SHIFT_REQ_OVF_EN  when defined, adds the sticky 'ovf' output. It sets when
//                     a request is offered while the buffer is full. That
//                     request is dropped.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst        synchronous, active-high reset
//   in_valid   producer offers a request
//   in_ready   buffer can accept a request (count != DEPTH)
//   in_data    operand to be rotated (32 bits)
//   in_shift   rotate amount 0..31
//   out_valid  head request available (count != 0)
//   out_ready  downstream consumes the head this cycle
//   out_data   head operand, 0 when empty
//   out_shift  head rotate amount, 0 when empty
//   count      number of occupied entries
//   ovf        sticky overflow flag (SHIFT_REQ_OVF_EN only)
// -----------------------------------------------------------------------------
module shift_req_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_data,
    input  logic [4:0]               in_shift,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_data,
    output logic [4:0]               out_shift,
    output logic [$clog2(DEPTH):0]   count
`ifdef SHIFT_REQ_OVF_EN
    ,
    output logic                     ovf
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 37;

    localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(1'b0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    // Storage and state
    logic [EW-1:0]  mem_r [DEPTH];
    logic [PW-1:0]  wr_ptr_r;
    logic [PW-1:0]  rd_ptr_r;
    logic [CW-1:0]  count_r;
    logic [EW-1:0]  head_r;
    logic           out_valid_r;
    logic           in_ready_r;

    // Next-state values
    logic           push_s;
    logic           pop_s;
    logic [PW-1:0]  wr_ptr_nxt_s;
    logic [PW-1:0]  rd_ptr_nxt_s;
    logic [CW-1:0]  count_nxt_s;
    logic           head_is_new_s;
    logic [EW-1:0]  head_nxt_s;
    logic [EW-1:0]  entry_in_s;

    // Handshakes depend only on registered ready/valid, so there is no
    // combinational path from in_valid or out_ready back to them.
    always_comb begin
        push_s     = in_valid & in_ready_r;
        pop_s      = out_valid_r & out_ready;
        entry_in_s = {in_data, in_shift};
    end

    // Pointer and occupancy update. Pointers are PW bits wide, so they wrap
    // modulo DEPTH without an explicit compare.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        count_nxt_s  = count_r;

        if (push_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end

        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end

        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            2'b11:   count_nxt_s = count_r;
            2'b00:   count_nxt_s = count_r;
            default: count_nxt_s = count_r;
        endcase
    end

    // Next head payload. A request written this edge becomes the head when
    // the buffer is empty after any pop. In that case the array slot is not
    // yet written, so the payload is taken from the input directly.
    always_comb begin
        head_is_new_s = 1'b0;
        head_nxt_s    = {EW{1'b0}};

        if ((count_r == CNT_ZERO) || ((count_r == CNT_ONE) && pop_s)) begin
            head_is_new_s = 1'b1;
        end else begin
            head_is_new_s = 1'b0;
        end

        if (count_nxt_s == CNT_ZERO) begin
            head_nxt_s = {EW{1'b0}};
        end else if (push_s && head_is_new_s) begin
            head_nxt_s = entry_in_s;
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // Control state and registered outputs. Reset overrides push and pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r    <= {PW{1'b0}};
            rd_ptr_r    <= {PW{1'b0}};
            count_r     <= CNT_ZERO;
            head_r      <= {EW{1'b0}};
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            wr_ptr_r    <= wr_ptr_nxt_s;
            rd_ptr_r    <= rd_ptr_nxt_s;
            count_r     <= count_nxt_s;
            head_r      <= head_nxt_s;
            out_valid_r <= (count_nxt_s != CNT_ZERO);
            in_ready_r  <= (count_nxt_s != CNT_FULL);
        end
    end

    // Entry storage. Reset clears the pointers only, so stale contents are
    // unreachable and the array itself is not cleared.
    always_ff @(posedge clk) begin
        if (push_s && !rst) begin
            mem_r[wr_ptr_r] <= entry_in_s;
        end
    end

`ifdef SHIFT_REQ_OVF_EN
    logic ovf_r;

    // Sticky overflow flag. It sets when a request is offered while the
    // buffer is full. The request itself is dropped because push_s is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else if (in_valid && !in_ready_r) begin
            ovf_r <= 1'b1;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    assign ovf = ovf_r;
`endif

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = head_r[EW-1:5];
    assign out_shift = head_r[4:0];
    assign count     = count_r;

endmodule

// File: tb/tb_shift_req_buffer.sv
// -----------------------------------------------------------------------------
// tb_shift_req_buffer
//
// Directed testbench for shift_req_buffer with DEPTH=4. Inputs change 1 ns
// after each rising edge. Outputs are checked in the same window. A
// reference right-rotate function stands in for the downstream rotator.
// -----------------------------------------------------------------------------
module tb_shift_req_buffer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_shift;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_shift;
    logic [2:0]  count;
`ifdef SHIFT_REQ_OVF_EN
    logic        ovf;
`endif

    int vectors;
    int errors;

    shift_req_buffer #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shift  (in_shift),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_shift (out_shift),
        .count     (count)
`ifdef SHIFT_REQ_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference 32-bit right rotate
    function automatic logic [31:0] ror(input logic [31:0] a, input logic [4:0] s);
        logic [63:0] t;
        t = {a, a} >> s;
        return t[31:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Directed stimulus
    initial begin
        vectors   = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        in_shift  = 5'd0;
        out_ready = 1'b0;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        chk("rst_count",     32'(count),     32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_data",  out_data,       32'h0);
        chk("rst_out_shift", 32'(out_shift), 32'd0);
`ifdef SHIFT_REQ_OVF_EN
        chk("rst_ovf",       32'(ovf),       32'd0);
`endif

        // Single request: visible one cycle after the push edge
        in_valid = 1'b1;
        in_data  = 32'h8000_0001;
        in_shift = 5'd1;
        tick();
        in_valid = 1'b0;
        in_data  = 32'hFFFF_FFFF;
        chk("one_valid", 32'(out_valid), 32'd1);
        chk("one_data",  out_data,       32'h8000_0001);
        chk("one_shift", 32'(out_shift), 32'd1);
        chk("one_count", 32'(count),     32'd1);
        chk("one_rot",   ror(out_data, out_shift), 32'hC000_0000);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("one_pop_count", 32'(count), 32'd0);
        chk("one_pop_data",  out_data,   32'h0);

        // Fill to DEPTH with no pops
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h1111_1111 * i;
            in_shift = 5'(i);
            tick();
        end
        chk("full_count",    32'(count),    32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        // Offer while full, no pop: nothing changes, head stays stable
        in_data = 32'hDEAD_0000;
        tick();
        in_valid = 1'b0;
        chk("full_hold_count", 32'(count), 32'd4);
        chk("full_hold_data",  out_data,   32'h1111_1111);
`ifdef SHIFT_REQ_OVF_EN
        chk("full_ovf", 32'(ovf), 32'd1);
`endif
        // Drain in order
        for (int i = 1; i <= 4; i++) begin
            chk("drain_data",  out_data,       32'h1111_1111 * i);
            chk("drain_shift", 32'(out_shift), 32'(i));
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        chk("drain_count", 32'(count),     32'd0);
        chk("drain_data0", out_data,       32'h0);
        chk("drain_valid", 32'(out_valid), 32'd0);

        // Steady state at count=2 with simultaneous push and pop, wrapping pointers
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            in_data  = 32'hA000_0000 + k;
            in_shift = 5'(k);
            tick();
        end
        chk("ss_count0", 32'(count), 32'd2);
        for (int k = 0; k < 10; k++) begin
            in_valid  = 1'b1;
            in_data   = 32'hA000_0000 + k + 2;
            in_shift  = 5'(k + 2);
            out_ready = 1'b1;
            chk("ss_data",  out_data,       32'hA000_0000 + k);
            chk("ss_shift", 32'(out_shift), 32'(k));
            tick();
            chk("ss_count", 32'(count), 32'd2);
        end
        in_valid = 1'b0;
        for (int k = 10; k < 12; k++) begin
            chk("ss_tail", out_data, 32'hA000_0000 + k);
            out_ready = 1'b1;
            tick();
        end
        out_ready = 1'b0;
        chk("ss_empty", 32'(count), 32'd0);

        // Full with offer and pop in the same cycle: pop only
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 32'hB000_0000 + i;
            in_shift = 5'(i);
            tick();
        end
        chk("fp_full", 32'(count), 32'd4);
        in_data   = 32'hBBBB_BBBB;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("fp_count",    32'(count),    32'd3);
        chk("fp_in_ready", 32'(in_ready), 32'd1);
        chk("fp_head",     out_data,      32'hB000_0001);
        tick();
        chk("fp_count_hold", 32'(count), 32'd3);
`ifdef SHIFT_REQ_OVF_EN
        chk("fp_ovf_sticky", 32'(ovf), 32'd1);
`endif

        // Reset with count=3 overrides a simultaneous push and pop
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h5555_5555;
        out_ready = 1'b1;
        tick();
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("mrst_count",    32'(count),     32'd0);
        chk("mrst_valid",    32'(out_valid), 32'd0);
        chk("mrst_data",     out_data,       32'h0);
        chk("mrst_in_ready", 32'(in_ready),  32'd1);
`ifdef SHIFT_REQ_OVF_EN
        chk("mrst_ovf",      32'(ovf),       32'd0);
`endif

        // Rotate-amount boundaries through the rotator model
        in_valid = 1'b1;
        in_data  = 32'h0000_0001;
        in_shift = 5'd31;
        tick();
        in_valid = 1'b0;
        chk("rot31_shift", 32'(out_shift), 32'd31);
        chk("rot31",       ror(out_data, out_shift), 32'h0000_0002);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h1234_5678;
        in_shift  = 5'd0;
        tick();
        in_valid = 1'b0;
        chk("rot0_shift", 32'(out_shift), 32'd0);
        chk("rot0",       ror(out_data, out_shift), 32'h1234_5678);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
